// File: rtl/stopwatch_display.sv
// Four-digit multiplexed seven-segment driver for the stopwatch.
// Frame-synchronous digit snapshot, leading-zero blanking, whole-display blink.
module stopwatch_display #(
   parameter int SCAN_DIV     = 250000,
   parameter int BLINK_FRAMES = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] disp_Tenths_Seconds,
   input  logic [3:0] disp_Ones_Seconds,
   input  logic [3:0] disp_Tens_Seconds,
   input  logic [3:0] disp_Minutes,
   input  logic       lz_blank,
   input  logic       blink_en,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an,
   output logic       frame_start
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PW-1:0] pc;
   logic [1:0]    idx;
   logic [3:0]    sh_m;
   logic [3:0]    sh_t;
   logic [3:0]    sh_o;
   logic [3:0]    sh_d;
   logic [BW-1:0] bc;
   logic          phase;

   logic          slot_end;
   logic          frame_end;
   logic [3:0]    cur;
   logic          blank;
   logic          dark;
   logic [6:0]    pat;

   assign slot_end  = (pc == PW'(SCAN_DIV - 1));
   assign frame_end = slot_end && (idx == 2'd3);

   // BCD to active-high gfedcba; anything above 9 shows a dash
   function automatic logic [6:0] bcd7(input logic [3:0] v);
      logic [6:0] p;
      case (v)
         4'd0:    p = 7'h3F;
         4'd1:    p = 7'h06;
         4'd2:    p = 7'h5B;
         4'd3:    p = 7'h4F;
         4'd4:    p = 7'h66;
         4'd5:    p = 7'h6D;
         4'd6:    p = 7'h7D;
         4'd7:    p = 7'h07;
         4'd8:    p = 7'h7F;
         4'd9:    p = 7'h6F;
         default: p = 7'h40;
      endcase
      return p;
   endfunction

   // Slot prescaler, digit index and frame-boundary snapshot of the inputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc          <= '0;
         idx         <= 2'd0;
         sh_m        <= 4'd0;
         sh_t        <= 4'd0;
         sh_o        <= 4'd0;
         sh_d        <= 4'd0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (slot_end) begin
            pc  <= '0;
            idx <= idx + 2'd1;
         end else begin
            pc <= pc + PW'(1);
         end
         if (frame_end) begin
            sh_m        <= disp_Minutes;
            sh_t        <= disp_Tens_Seconds;
            sh_o        <= disp_Ones_Seconds;
            sh_d        <= disp_Tenths_Seconds;
            frame_start <= 1'b1;
         end
      end
   end

   // Blink frame counter; held cleared whenever blinking is disabled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bc    <= '0;
         phase <= 1'b0;
      end else if (!blink_en) begin
         bc    <= '0;
         phase <= 1'b0;
      end else if (frame_end) begin
         if (bc == BW'(BLINK_FRAMES - 1)) begin
            bc    <= '0;
            phase <= ~phase;
         end else begin
            bc <= bc + BW'(1);
         end
      end
   end

   // Select the current digit and decide whether its anode stays dark
   always_comb begin
      cur = sh_d;
      unique case (idx)
         2'd0: cur = sh_d;
         2'd1: cur = sh_o;
         2'd2: cur = sh_t;
         2'd3: cur = sh_m;
      endcase
      blank = lz_blank &&
              (((idx == 2'd3) && (sh_m == 4'd0)) ||
               ((idx == 2'd2) && (sh_m == 4'd0) && (sh_t == 4'd0)));
      dark  = (pc == '0) || blank || (blink_en && phase);
      pat   = bcd7(cur);
   end

   // Registered segment, decimal point and anode drive
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         an  <= 4'hF;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         an  <= dark ? 4'hF : ~(4'b0001 << idx);
         seg <= ~pat;
         dp  <= ~idx[0];
      end
   end

endmodule

// File: tb/tb_stopwatch_display.sv
// Scoreboard bench for stopwatch_display.
// Expected lit digit slots are queued per frame and checked by a monitor.
module tb_stopwatch_display;

   logic       clk;
   logic       reset;
   logic [3:0] d_t;
   logic [3:0] d_o;
   logic [3:0] d_ts;
   logic [3:0] d_m;
   logic       lz_blank;
   logic       blink_en;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;
   logic       frame_start;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   exp_t q[$];
   int   checks;
   int   failures;
   bit   armed;
   logic [3:0] prev_an;

   stopwatch_display #(
      .SCAN_DIV(4),
      .BLINK_FRAMES(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .disp_Tenths_Seconds(d_t),
      .disp_Ones_Seconds(d_o),
      .disp_Tens_Seconds(d_ts),
      .disp_Minutes(d_m),
      .lz_blank(lz_blank),
      .blink_en(blink_en),
      .seg(seg),
      .dp(dp),
      .an(an),
      .frame_start(frame_start)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // monitor: each newly lit digit slot is compared with the queue head
   initial begin
      exp_t e;
      prev_an = 4'hF;
      forever begin
         @(negedge clk);
         if (armed && an != 4'hF && prev_an == 4'hF) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL extra_slot an=%h seg=%h dp=%b required no lit slot",
                        an, seg, dp);
            end else begin
               e = q.pop_front();
               if ({an, seg, dp} !== e) begin
                  failures++;
                  $display("FAIL slot an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                           an, seg, dp, e.an, e.seg, e.dp);
               end
            end
         end
         prev_an = an;
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push(input logic [3:0] a, input logic [6:0] s,
                       input logic p);
      exp_t e;
      e.an  = a;
      e.seg = s;
      e.dp  = p;
      q.push_back(e);
   endtask

   task automatic push4(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3);
      push(4'hE, s0, 1'b1);
      push(4'hD, s1, 1'b0);
      push(4'hB, s2, 1'b1);
      push(4'h7, s3, 1'b0);
   endtask

   task automatic next_frame(input int exp_n);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_start && n < 64);
      chk("frame_len", n, exp_n);
      chk("frame_drain", q.size(), 0);
      q.delete();
   endtask

   initial begin
      int n;
      checks   = 0;
      failures = 0;
      armed    = 1'b0;
      reset    = 1'b0;
      d_m      = 4'd0;
      d_ts     = 4'd0;
      d_o      = 4'd0;
      d_t      = 4'd0;
      lz_blank = 1'b0;
      blink_en = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_an", an, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", dp, 1'b1);
      chk("rst_fs", frame_start, 1'b0);

      // first frame shows reset shadows; inputs captured at first wrap
      d_m   = 4'd1;
      d_ts  = 4'd2;
      d_o   = 4'd3;
      d_t   = 4'd4;
      reset = 1'b1;
      armed = 1'b1;
      push4(7'h40, 7'h40, 7'h40, 7'h40);
      next_frame(16);

      // basic scan of 1:23.4
      push4(7'h19, 7'h30, 7'h24, 7'h79);
      next_frame(16);

      // change tenths while digit 1 is on; rest of frame unaffected
      push4(7'h19, 7'h30, 7'h24, 7'h79);
      n = 0;
      while (an != 4'hD && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("reach_d1", an, 4'hD);
      d_t = 4'd9;
      next_frame(10);
      push4(7'h10, 7'h30, 7'h24, 7'h79);
      lz_blank = 1'b1;
      d_m      = 4'd0;
      d_ts     = 4'd0;
      d_o      = 4'd7;
      d_t      = 4'd4;
      next_frame(16);

      // leading zeros: digits 3 and 2 blanked
      push(4'hE, 7'h19, 1'b1);
      push(4'hD, 7'h78, 1'b0);
      d_ts = 4'd5;
      next_frame(16);
      push(4'hE, 7'h19, 1'b1);
      push(4'hD, 7'h78, 1'b0);
      push(4'hB, 7'h12, 1'b1);
      next_frame(16);
      lz_blank = 1'b0;
      push4(7'h19, 7'h78, 7'h12, 7'h40);
      next_frame(16);

      // blink: two frames on, two off, release mid off-frame
      blink_en = 1'b1;
      push4(7'h19, 7'h78, 7'h12, 7'h40);
      next_frame(16);
      push4(7'h19, 7'h78, 7'h12, 7'h40);
      next_frame(16);
      next_frame(16);
      push(4'hD, 7'h78, 1'b0);
      push(4'hB, 7'h12, 1'b1);
      push(4'h7, 7'h40, 1'b0);
      repeat (6) @(negedge clk);
      chk("blink_off_an", an, 4'hF);
      blink_en = 1'b0;
      @(negedge clk);
      chk("blink_resume_an", an, 4'hD);
      next_frame(9);

      // invalid BCD on ones-of-seconds shows a dash
      d_m  = 4'd1;
      d_ts = 4'd2;
      d_o  = 4'hC;
      d_t  = 4'd4;
      push4(7'h19, 7'h78, 7'h12, 7'h40);
      next_frame(16);
      push4(7'h19, 7'h3F, 7'h24, 7'h79);
      next_frame(16);

      // asynchronous reset in the middle of a lit slot
      armed = 1'b0;
      repeat (6) @(negedge clk);
      chk("pre_rst_an", an, 4'hD);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_an", an, 4'hF);
      chk("mid_rst_seg", seg, 7'h7F);
      chk("mid_rst_dp", dp, 1'b1);
      chk("mid_rst_fs", frame_start, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stopwatch_display.md
# stopwatch_display

Four-digit multiplexed seven-segment driver sitting directly downstream of `stopwatch`. It consumes the four BCD digit outputs (`disp_Minutes`, `disp_Tens_Seconds`, `disp_Ones_Seconds`, `disp_Tenths_Seconds`) and time-multiplexes them onto a common segment bus with per-digit anode enables. Each frame it captures a tear-free snapshot of the digits and shows them as M.TO.t. It also provides leading-zero blanking and a whole-display blink for TimeSet/Lap-hold indication.

## Interface
- `SCAN_DIV`, 250000: clk cycles per digit slot; minimum 2. Frame = 4*SCAN_DIV cycles.
- `BLINK_FRAMES`, 25: frames per blink half-period; minimum 1.
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `disp_Tenths_Seconds` in 4: BCD, digit 0 (rightmost).
- `disp_Ones_Seconds` in 4: BCD, digit 1.
- `disp_Tens_Seconds` in 4: BCD, digit 2.
- `disp_Minutes` in 4: BCD, digit 3 (leftmost).
- `lz_blank` in 1: enables leading-zero blanking of digits 3/2.
- `blink_en` in 1: enables whole-display blink.
- `seg` out 7: segments, bit0=a … bit6=g, active-low.
- `dp` out 1: decimal point, active-low.
- `an` out 4: digit anode enables, `an[k]` = digit k, active-low.
- `frame_start` out 1: one-cycle pulse when a new snapshot is taken.

## Operation
- Prescaler `pc` counts 0..SCAN_DIV-1. On the edge where `pc`==SCAN_DIV-1: `pc`←0 and digit index `idx`←(idx+1) mod 4.
- Snapshot: on the edge where `idx` wraps 3→0, the four shadow registers load the current inputs and `frame_start`←1. On all other edges `frame_start`←0. Inputs are never read outside this edge.
- Decode of a shadow value to active-high gfedcba: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F. Values 10–15 → 40 (g only, dash). `seg` is the bitwise inverse of this pattern.
- `dp` is lit on digits 1 and 3; it separates seconds.tenths and minutes.tens.
- Leading-zero blanking, when `lz_blank`=1:
  - digit 3 is blank if shadow M==0;
  - digit 2 is blank if shadow M==0 and shadow T==0.
  - A blank digit has its anode inactive for the whole slot. Blanking is evaluated from the shadows, so it changes only at a frame boundary.
- Blink: frame counter `bc` counts frames 0..BLINK_FRAMES-1 and toggles `phase` at each wrap, advancing at each `frame_start` edge.
  - While `blink_en`=1 and `phase`=1, all anodes are inactive.
  - While `blink_en`=0, `bc`←0 and `phase`←0.
- Ghost guard: all anodes are inactive for the first cycle of every slot (`pc`==0 in the registered computation).

## Timing
- `seg`, `dp`, `an` are registered. Each edge computes them from the current `idx`, `pc`, shadows, `phase` and `blink_en`, so the outputs lag the counters by one clock.
- Digit k anode is active for SCAN_DIV-1 cycles per frame. There is one guard cycle between consecutive digits.
- Input-to-display latency:
  - best case 1 clock after the snapshot edge, plus the guard cycle;
  - worst case 4*SCAN_DIV+2 cycles.
- Reset (asynchronous, while `reset`=0): `pc`=0, `idx`=0, shadows=0, `bc`=0, `phase`=0, `frame_start`=0, `an`=4'hF, `seg`=7'h7F, `dp`=1. This holds even if reset is asserted mid-slot.
- First frame after reset release displays the reset shadows (0000). Inputs are first sampled at the first 3→0 wrap, 4*SCAN_DIV edges after release.
- Simultaneous events:
  - `blink_en` rising on a `frame_start` edge: `bc` stays 0 and blink counting starts from the next frame.
  - `blink_en` falling takes effect on the next output register update, i.e. the display resumes mid-frame.
- `lz_blank` is applied combinationally into the output register and may change at any cycle; it acts on shadow values only.

## Test plan
All scenarios use SCAN_DIV=4, BLINK_FRAMES=2.
- **Reset:** assert `reset`=0 mid-slot → same cycle `an`=F, `seg`=7F, `dp`=1, `frame_start`=0. Release → `an` cycles E,D,B,7 (with F guard cycles) showing `seg`=40 on every digit, `dp`=0 on digits 1 and 3.
- **Basic scan:** M=1, T=2, O=3, t=4, held; after first `frame_start` → next frame shows `an`=E/`seg`=19, D/30, B/24, 7/79. `dp`=0 only with D and 7. `frame_start` period is 16 cycles.
- **Snapshot isolation:** change t 4→9 while `idx`=1 → digit 0 still shows 19 until after the next `frame_start`, then shows 10.
- **Leading zeros:** `lz_blank`=1, M=0, T=0, O=7 → `an[3]` and `an[2]` never low, `an[1]` shows 78. Set T=5 → from next frame `an[2]` low with `seg`=12. Set `lz_blank`=0 → `an[3]` low with `seg`=40.
- **Blink:** `blink_en`=1 → 2 frames displayed, 2 frames all-anodes-off, repeating. Deassert during an off phase → `an` resumes within 1 clock.
- **Invalid BCD:** disp_Ones_Seconds=4'hC → digit 1 shows `seg`=3F with `dp`=0.
